// File: rtl/prbs31_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs31_pkg
//  Description : Shared constants, state encoding and feedback helper for the
//                PRBS31 (x^31 + x^28 + 1) burst sequencer and checker.
//  Revision    : 1.0  initial release
// ============================================================================
package prbs31_pkg;

    // Generator / checker register width and feedback taps
    localparam int PRBS_W   = 31;
    localparam int TAP_HI   = 30;
    localparam int TAP_LO   = 27;

    // Value loaded after reset and substituted for an all-zero seed
    localparam logic [PRBS_W-1:0] PRBS_DEFAULT_SEED = 31'h7FFF_FFFF;

    // Checker fill counter: counts 0..31 valid bits, locked at the top value
    localparam int              FILL_W    = 5;
    localparam logic [FILL_W-1:0] FILL_FULL = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Next pattern bit predicted from a 31-bit history, newest bit in [0]
    function automatic logic prbs_fb(input logic [PRBS_W-1:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs31_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : prbs31_lfsr
//  Description : PRBS31 Fibonacci LFSR. Loads a seed (zero replaced by the
//                all-ones default so the register can never lock up), steps
//                on request, and exposes the next output bit directly from
//                the state register.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs31_lfsr
    import prbs31_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PRBS_W-1:0] seed,
    input  logic              step,
    output logic              bit_out
);

    logic [PRBS_W-1:0] lfsr_q;
    logic [PRBS_W-1:0] seed_eff;

    // An all-zero state is the one fixed point of the LFSR; never load it
    assign seed_eff = (seed == '0) ? PRBS_DEFAULT_SEED : seed;

    // Seed load takes precedence over stepping; otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= PRBS_DEFAULT_SEED;
        end else if (load) begin
            lfsr_q <= seed_eff;
        end else if (step) begin
            lfsr_q <= {lfsr_q[PRBS_W-2:0], prbs_fb(lfsr_q)};
        end
    end

    // Output bit is the feedback of the current state: one XOR, no pipeline
    assign bit_out = prbs_fb(lfsr_q);

endmodule
`default_nettype wire

// File: rtl/prbs31_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs31_burst_ctrl
//  Description : Burst sequencer and self-synchronising loopback checker for
//                the PRBS31 pattern datapath. Seeds the generator, runs it
//                for a programmed number of cycles with a valid strobe, and
//                reports lock, a saturating error count and a done pulse.
//  Options     : PRBS31_ERR_INJECT_EN - adds inject_err, which inverts tx_bit
//                for one RUN cycle without disturbing the LFSR sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs31_burst_ctrl
    import prbs31_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int ERR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PRBS_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              rx_bit,
    input  logic              rx_valid,
`ifdef PRBS31_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic [ERR_W-1:0]  err_cnt
);

    state_t             state;
    state_t             state_n;
    logic [LEN_W-1:0]   remaining;
    logic               accept;
    logic               in_run;
    logic               gen_bit;
    logic               flip_bit;

    logic [PRBS_W-1:0]  rx_sr;
    logic [FILL_W-1:0]  fill;
    logic               mismatch;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------

    // A start is only taken from IDLE; a simultaneous abort is ignored there
    assign accept = (state == IDLE) && start;
    assign in_run = (state == RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; abort beats every transition out of a busy state
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (remaining != '0) begin
                    state_n = RUN;
                end else begin
                    state_n = DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (remaining == LEN_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Burst length latched on acceptance, counted down once per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (accept) begin
            remaining <= burst_len;
        end else if (in_run) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Generator: seeded during LOAD, advanced in every RUN cycle
    prbs31_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (state == LOAD),
        .seed    (seed),
        .step    (in_run),
        .bit_out (gen_bit)
    );

`ifdef PRBS31_ERR_INJECT_EN
    // Inversion sits after the LFSR feedback so the sequence itself is intact
    assign flip_bit = inject_err;
`else
    assign flip_bit = 1'b0;
`endif

    assign tx_bit   = in_run & (gen_bit ^ flip_bit);
    assign tx_valid = in_run;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // ------------------------------------------------------------------
    // Checker: runs on every valid receive bit regardless of sequencer state
    // ------------------------------------------------------------------

    assign locked   = (fill == FILL_FULL);
    assign mismatch = rx_valid && locked && (rx_bit != prbs_fb(rx_sr));

    // Receive history; only valid bits enter it
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr <= '0;
        end else if (rx_valid) begin
            rx_sr <= {rx_sr[PRBS_W-2:0], rx_bit};
        end
    end

    // Fill counter; an accepted start forces re-acquisition of lock
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else if (accept) begin
            fill <= '0;
        end else if (rx_valid && !locked) begin
            fill <= fill + FILL_W'(1);
        end
    end

    // Saturating mismatch counter, cleared by an accepted start only
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (mismatch && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs31_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs31_burst_ctrl
//  Description : Self-checking bench for prbs31_burst_ctrl. A cycle table
//                covers sequencing; hand-written sequences cover seeding,
//                loopback lock, error counting, saturation, abort and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prbs31_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [30:0] seed;
    logic [15:0] burst_len;
    logic        rx_bit_drv;
    logic        rx_valid_drv;
    logic        lb_en;
    logic        flip;
    logic        rx_bit;
    logic        rx_valid;
`ifdef PRBS31_ERR_INJECT_EN
    logic        inject_err;
    int          inj_at;
`endif

    logic        tx_bit, tx_valid, busy, done, locked;
    logic [15:0] err_cnt;
    logic        tx_bit4, tx_valid4, busy4, done4, locked4;
    logic [3:0]  err_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    // Captured burst results
    logic [255:0] bits_cap;
    int           nv_cap;
    int           nd_cap;
    logic         l31, l32;
    logic [15:0]  e50, e51;

    always #5 clk = ~clk;

    // Loopback path: returned stream is the transmitted one, optionally flipped
    assign rx_bit   = lb_en ? (tx_bit ^ flip) : rx_bit_drv;
    assign rx_valid = lb_en ? tx_valid        : rx_valid_drv;

    prbs31_burst_ctrl #(.LEN_W(16), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .burst_len(burst_len), .rx_bit(rx_bit), .rx_valid(rx_valid),
`ifdef PRBS31_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done),
        .locked(locked), .err_cnt(err_cnt)
    );

    prbs31_burst_ctrl #(.LEN_W(16), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .burst_len(burst_len), .rx_bit(rx_bit), .rx_valid(rx_valid),
`ifdef PRBS31_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .tx_bit(tx_bit4), .tx_valid(tx_valid4), .busy(busy4), .done(done4),
        .locked(locked4), .err_cnt(err_cnt4)
    );

    typedef struct packed {
        logic        start;
        logic        abort;
        logic [30:0] seed;
        logic [15:0] len;
        logic [3:0]  exp;   // {tx_bit, tx_valid, busy, done}
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference PRBS31 stream: b[t] = b[t-31] ^ b[t-28]
    function automatic logic [255:0] model(input logic [30:0] sd, input int n);
        logic [30:0]  s;
        logic [255:0] m;
        logic         b;
        m = '0;
        s = (sd == 31'd0) ? 31'h7FFF_FFFF : sd;
        for (int i = 0; i < n; i++) begin
            b    = s[30] ^ s[27];
            m[i] = b;
            s    = {s[29:0], b};
        end
        return m;
    endfunction

    // Run one burst from IDLE; flip_at/abort_at are 1-based RUN cycle numbers
    task automatic burst(input logic [30:0] sd, input int len, input int flip_at, input int abort_at);
        int cyc;
        bits_cap = '0; nv_cap = 0; nd_cap = 0;
        l31 = 1'bx; l32 = 1'bx; e50 = 'x; e51 = 'x;
        seed = sd; burst_len = 16'(len); start = 1'b1;
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < len + 8) begin
            flip  = tx_valid && (nv_cap + 1 == flip_at);
            abort = tx_valid && (nv_cap + 1 == abort_at);
`ifdef PRBS31_ERR_INJECT_EN
            inject_err = tx_valid && (nv_cap + 1 == inj_at);
`endif
            @(negedge clk);
            if (tx_valid) begin
                bits_cap[nv_cap] = tx_bit;
                nv_cap++;
                if (nv_cap == 31) l31 = locked;
                if (nv_cap == 32) l32 = locked;
                if (nv_cap == 50) e50 = err_cnt;
                if (nv_cap == 51) e51 = err_cnt;
            end
            if (done) nd_cap++;
            next_cycle();
            cyc++;
        end
        flip = 1'b0; abort = 1'b0;
`ifdef PRBS31_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL burst_timeout: busy still 1 after %0d cycles, required 0", cyc);
        end
    endtask

    initial begin
        logic [255:0] ref_bits;

        // {start, abort, seed, len, {tx_bit, tx_valid, busy, done}}
        tv[0]  = '{1'b1, 1'b0, 31'h4000_0000, 16'd4, 4'b0000};
        tv[1]  = '{1'b0, 1'b0, 31'h4000_0000, 16'd4, 4'b0010};  // LOAD
        tv[2]  = '{1'b0, 1'b0, 31'h4000_0000, 16'd4, 4'b1110};
        tv[3]  = '{1'b1, 1'b0, 31'h4000_0000, 16'd4, 4'b0110};  // start while busy
        tv[4]  = '{1'b0, 1'b0, 31'h4000_0000, 16'd4, 4'b0110};
        tv[5]  = '{1'b0, 1'b0, 31'h4000_0000, 16'd4, 4'b0110};
        tv[6]  = '{1'b0, 1'b0, 31'h4000_0000, 16'd4, 4'b0011};  // DONE
        tv[7]  = '{1'b0, 1'b0, 31'h4000_0000, 16'd4, 4'b0000};
        tv[8]  = '{1'b1, 1'b0, 31'h1357_9BDF, 16'd0, 4'b0000};  // N = 0
        tv[9]  = '{1'b0, 1'b0, 31'h1357_9BDF, 16'd0, 4'b0010};
        tv[10] = '{1'b0, 1'b0, 31'h1357_9BDF, 16'd0, 4'b0011};
        tv[11] = '{1'b0, 1'b0, 31'h1357_9BDF, 16'd0, 4'b0000};
        tv[12] = '{1'b1, 1'b1, 31'h0000_0F0F, 16'd5, 4'b0000};  // start wins
        tv[13] = '{1'b0, 1'b1, 31'h0000_0F0F, 16'd5, 4'b0010};  // abort in LOAD
        tv[14] = '{1'b0, 1'b0, 31'h0000_0F0F, 16'd5, 4'b0000};

        rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; burst_len = '0;
        rx_bit_drv = 1'b0; rx_valid_drv = 1'b0; lb_en = 1'b0; flip = 1'b0;
`ifdef PRBS31_ERR_INJECT_EN
        inject_err = 1'b0; inj_at = 0;
`endif
        repeat (3) next_cycle();
        rst = 1'b0;

        // Idle after reset: everything low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("reset_idle%0d", i),
                  {tx_bit, tx_valid, busy, done, locked, err_cnt}, '0);
            next_cycle();
        end

        // Cycle table
        for (int i = 0; i < NV; i++) begin
            start = tv[i].start; abort = tv[i].abort;
            seed = tv[i].seed; burst_len = tv[i].len;
            @(negedge clk);
            check($sformatf("vec%0d", i), {tx_bit, tx_valid, busy, done}, tv[i].exp);
            next_cycle();
        end
        start = 1'b0; abort = 1'b0;

        // Default seed and the zero-seed substitution give the same stream
        burst(31'h7FFF_FFFF, 40, 0, 0);
        ref_bits = bits_cap;
        check("seed_ones_stream", bits_cap, model(31'h7FFF_FFFF, 40));
        check("seed_ones_count", nv_cap, 40);
        check("seed_ones_done", nd_cap, 1);
        burst(31'd0, 40, 0, 0);
        check("seed_zero_stream", bits_cap, ref_bits);
        check("seed_zero_done", nd_cap, 1);

        // Clean loopback
        lb_en = 1'b1;
        burst(31'h1234_5678, 200, 0, 0);
        check("lb_stream", bits_cap, model(31'h1234_5678, 200));
        check("lb_locked_at31", l31, 1'b0);
        check("lb_locked_at32", l32, 1'b1);
        check("lb_err_final", err_cnt, 16'd0);
        check("lb_done", nd_cap, 1);

        // One flipped return bit: three mismatches, counted a cycle late
        burst(31'h0ABC_DEF1, 100, 50, 0);
        check("flip_err_before", e50, 16'd0);
        check("flip_err_after", e51, 16'd1);
        check("flip_err_final", err_cnt, 16'd3);

`ifdef PRBS31_ERR_INJECT_EN
        inj_at = 50;
        burst(31'h2468_ACE1, 100, 0, 0);
        inj_at = 0;
        check("inject_err_final", err_cnt, 16'd3);
`endif
        lb_en = 1'b0;

        // Abort in RUN cycle 3 of a 10-bit burst
        burst(31'h5555_AAAA, 10, 0, 3);
        check("abort_run_cycles", nv_cap, 3);
        check("abort_no_done", nd_cap, 0);

        // Continuous mismatches during a burst, then abort holds the counters
        seed = 31'h0F0F_0F0F; burst_len = 16'd200; start = 1'b1;
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        rx_bit_drv = 1'b1; rx_valid_drv = 1'b1;
        repeat (51) next_cycle();   // 31 to lock, then 20 mismatches
        rx_valid_drv = 1'b0; rx_bit_drv = 1'b0;
        @(negedge clk);
        check("sat_err16", err_cnt, 16'd20);
        check("sat_err4", err_cnt4, 4'd15);
        check("sat_busy", busy, 1'b1);
        next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", {busy, done, tx_valid}, 3'b000);
        check("abort_err_held", err_cnt, 16'd20);
        check("abort_locked_held", locked, 1'b1);

        // Reset in the middle of a burst
        next_cycle();
        seed = 31'h7654_3210; burst_len = 16'd50; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        check("mid_burst_running", tx_valid, 1'b1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("mid_burst_reset",
              {tx_bit, tx_valid, busy, done, locked, err_cnt, err_cnt4}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
